rsa_encrypt_core: RTL

- Sequential modular-exponentiation engine for the RSA encryption (public-key) side of the datapath: computes res_out = m^e mod n on DATA_WIDTH-bit operands.
- Counterpart to the MonPro decryption path. Its ciphertext output feeds MonPro's m_input; the same n is used with the private exponent.
- Uses interleaved bit-serial modular multiplication (no Montgomery domain conversion) with left-to-right square-and-multiply.
- Result is held under a done/getResult handshake.

---
 rtl/rsa_encrypt_core_if.sv | 25 ++
 rtl/rsa_encrypt_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rsa_encrypt_core_if.sv
// rtl/rsa_encrypt_core_if.sv - start/operand/result bundle for the RSA encryption engine
interface rsa_encrypt_core_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  startInput;
  logic                  getResult;
  logic [DATA_WIDTH-1:0] m_input;
  logic [DATA_WIDTH-1:0] e_input;
  logic [DATA_WIDTH-1:0] n_input;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] res_out;
  logic [2:0]            state;

  modport master (
    output startInput, getResult, m_input, e_input, n_input,
    input  busy, done, error, res_out, state
  );

  modport slave (
    input  startInput, getResult, m_input, e_input, n_input,
    output busy, done, error, res_out, state
  );
endinterface

// File: rtl/rsa_encrypt_core.sv
// rtl/rsa_encrypt_core.sv - m^e mod n by left-to-right square-and-multiply over bit-serial modmul
module rsa_encrypt_core #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 7
) (
  input logic               clk,
  input logic               reset,
  rsa_encrypt_core_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SCAN  = 3'd2,
    SQR   = 3'd3,
    MUL   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         m_q, m_d, e_q, e_d, n_q, n_d;
  logic [W-1:0]         acc_q, acc_d, p_q, p_d, b_q, b_d, res_q, res_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, k_q, k_d, i_q, i_d;
  logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;

  // One modmul iteration: P = 2P mod n, then optionally + acc mod n.
  // Both reductions are a single subtract because P, acc < n.
  logic [W:0]   dbl, sum;
  logic [W-1:0] red1, red2, p_step;

  always_comb begin
    dbl    = {p_q, 1'b0};
    red1   = (dbl >= {1'b0, n_q}) ? W'(dbl - {1'b0, n_q}) : W'(dbl);
    sum    = {1'b0, red1} + {1'b0, acc_q};
    red2   = (sum >= {1'b0, n_q}) ? W'(sum - {1'b0, n_q}) : W'(sum);
    p_step = b_q[W-1] ? red2 : red1;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    n_d     = n_q;
    acc_d   = acc_q;
    p_d     = p_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    i_d     = i_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      IDLE: begin
        if (bus.startInput) begin
          m_d     = bus.m_input;
          e_d     = bus.e_input;
          n_d     = bus.n_input;
          busy_d  = 1'b1;
          error_d = 1'b0;
          cnt_d   = LAST_BIT;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (n_q == '0 || m_q >= n_q) begin
          error_d = 1'b1;
          acc_d   = '0;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (e_q == '0) begin
          acc_d   = (n_q == W'(1)) ? '0 : W'(1);
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        e_d = e_q << 1;
        if (e_q[W-1]) begin
          acc_d = m_q;
          if (cnt_q == '0) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            k_d     = cnt_q;
            p_d     = '0;
            b_d     = m_q;
            i_d     = LAST_BIT;
            state_d = SQR;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SQR, MUL: begin
        p_d = p_step;
        b_d = b_q << 1;
        i_d = i_q - 1'b1;
        if (i_q == '0) begin
          acc_d = p_step;
          p_d   = '0;
          i_d   = LAST_BIT;
          // e_q[W-1] is the exponent bit belonging to the square just finished
          if (state_q == SQR && e_q[W-1]) begin
            b_d     = m_q;
            state_d = MUL;
          end else begin
            e_d = e_q << 1;
            k_d = k_q - 1'b1;
            if (k_q == CNT_WIDTH'(1)) begin
              busy_d  = 1'b0;
              state_d = DONE;
            end else begin
              b_d     = p_step;
              state_d = SQR;
            end
          end
        end
      end
      DONE: begin
        if (!done_q) begin
          done_d = 1'b1;
          res_d  = error_q ? '0 : acc_q;
        end else if (bus.getResult) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.res_out = res_q;
  assign bus.state   = state_q;
endmodule
